serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
// - Downstream consumer of the negedge D flip-flop: takes the registered serial bit (q)
//   and assembles framed words: start bit 0, WIDTH data bits LSB-first, stop bit 1.
// - Presents the completed word in parallel with a one-cycle valid strobe and flags
//   framing errors.
// - All state registers update on negedge clk, the same edge as the flip-flop feeding sin.
// PARAMETERS
// - WIDTH   8   data bits per frame (legal range 2..16)
// PORTS
// - clk         in   1      clock; all sequential logic on negedge
// - clr_n       in   1      reset, asynchronous, active-low
// - sin         in   1      serial bit from upstream D flip-flop q
// - en          in   1      bit strobe: sin sampled only on negedges where en=1
// - data_out    out  WIDTH  last good word; held until the next good frame
// - valid       out  1      1-cycle pulse: data_out updated this cycle
// - frame_err   out  1      1-cycle pulse: stop bit sampled as 0
// - parity_err  out  1      1-cycle pulse: parity mismatch (see CONFIGURATION)
// - busy        out  1      1 whenever FSM is not in IDLE
// BEHAVIOUR
// - Reset: clr_n=0 forces IDLE immediately, independent of clk. Also clears
//   data_out, the shift register and the bit counter, and drives valid=0,
//   frame_err=0, parity_err=0, busy=0. Applies mid-frame too; the partial word
//   is discarded.
// - en=0 on an edge: FSM, counter and shift register hold; pulses are still cleared.
// - IDLE:   en & sin=0 -> DATA, bitcnt=0. en & sin=1 -> stay.
// - DATA:   en -> shift sin into MSB, shifting right, so the first-received bit
//   lands at bit 0. bitcnt+1. After WIDTH data bits -> PARITY if enabled, else STOP.
// - PARITY: en -> capture parity bit -> STOP.
// - STOP:   en & sin=1 -> data_out<=shift, valid=1, and parity_err=1 if the check
//   failed; -> IDLE.
//           en & sin=0 -> frame_err=1, valid=0, data_out unchanged; -> IDLE.
//   A stop bit sampled as 0 is never reinterpreted as a start bit.
// - Pulses last exactly one clk period, even if en stays 1.
// - Latency: valid rises on the negedge that samples the stop bit.
//   With en tied high, that is the (WIDTH+2)th sampling edge after the start edge
//   when parity is included, or WIDTH+1 without parity.
// - Back-to-back frames: a start bit may be sampled on the first en edge after STOP,
//   so there is no dead cycle.
// - bitcnt width is clog2(WIDTH+1) and never wraps; the DATA exit is at bitcnt==WIDTH-1.
// CONFIGURATION
// - `define SERIAL_FRAME_RX_PARITY_EN:
//   - adds the PARITY state and one even-parity bit after the data bits;
//   - the check is XOR(data bits, parity bit) must equal 0;
//   - on a mismatch with a good stop bit, valid=1 and parity_err=1 in the same
//     cycle, and data_out is still updated.
// - Macro undefined: no PARITY state, the frame is WIDTH+2 bits, and parity_err is
//   tied to 0.
// TESTING  (WIDTH=8, en=1 unless stated; bits listed in arrival order)
// - Reset: clr_n=0 at any time -> data_out=8'h00, valid=0, frame_err=0, busy=0
//   immediately, with no clk edge needed.
// - Good frame 0xA5: sin=0,1,0,1,0,0,1,0,1,1 -> busy=1 after the start edge; one
//   valid pulse on the 10th edge; data_out=8'hA5; frame_err=0.
// - Bad stop: 0,1,1,1,1,0,0,0,0,0 -> frame_err pulses once, valid=0,
//   data_out stays 8'hA5, FSM returns to IDLE.
// - Strobe gaps: en alternating 1/0 while sending 0x3C -> data_out=8'h3C after
//   20 clocks; sin changes while en=0 are ignored.
// - Reset mid-frame: clr_n pulsed low after 4 data bits -> busy=0; the following
//   0xFF frame is received correctly and the first valid shows 8'hFF.
// - PARITY_EN: 0x07 with parity bit 1 -> valid=1, parity_err=0. The same frame
//   with parity bit 0 -> valid=1, parity_err=1, data_out=8'h07.

Source files
------------

// File: rtl/serial_frame_rx_if.sv
// Bundle of the serial-frame receiver's bit-stream inputs and word/status outputs.
// master drives the bit stream; slave is the receiver.
interface serial_frame_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sin;
  logic             en;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             frame_err;
  logic             parity_err;
  logic             busy;

  modport master (
    output sin, en,
    input  data_out, valid, frame_err, parity_err, busy
  );

  modport slave (
    input  sin, en,
    output data_out, valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Negedge-clocked receiver for start/data(LSB first)/[parity]/stop serial frames.
// Optional even-parity bit enabled by `define SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  serial_frame_rx_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bitcnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             busy_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic             par_bit;
  logic             parity_err_q;
`endif

  // Frame FSM; pulses default low every edge so they never outlast one clock.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= IDLE;
      bitcnt       <= '0;
      shift        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (bus.en) begin
        case (state)
          IDLE: begin
            if (!bus.sin) begin
              state  <= DATA;
              bitcnt <= '0;
              busy_q <= 1'b1;
            end
          end
          DATA: begin
            shift <= {bus.sin, shift[WIDTH-1:1]};
            if (bitcnt == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bitcnt <= bitcnt + CNT_W'(1);
            end
          end
          PARITY: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bit <= bus.sin;
`endif
            state <= STOP;
          end
          STOP: begin
            // A zero stop bit is an error, never a new start bit.
            if (bus.sin) begin
              data_q  <= shift;
              valid_q <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
              parity_err_q <= (^shift) ^ par_bit;
`endif
            end else begin
              frame_err_q <= 1'b1;
            end
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: frame-level reference model, randomized frames.
module tb_serial_frame_rx;
  localparam int unsigned W = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    bit         good;
    logic [W-1:0] data;
    bit         perr;
  } exp_t;

  logic clk;
  logic clr_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [W-1:0] exp_dout;

  serial_frame_rx_if #(.WIDTH(W)) bus_if ();

  serial_frame_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the next frame outcome predicted by the model.
  always @(posedge clk) begin
    if (clr_n === 1'b1 && (bus_if.valid !== 1'b0 || bus_if.frame_err !== 1'b0 ||
                           bus_if.parity_err !== 1'b0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, bus_if.valid, bus_if.frame_err, bus_if.parity_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.good) exp_dout = e.data;
        chk("valid",      32'(bus_if.valid),      32'(e.good));
        chk("frame_err",  32'(bus_if.frame_err),  32'(!e.good));
        chk("parity_err", 32'(bus_if.parity_err), 32'(e.perr));
        chk("data_out",   32'(bus_if.data_out),   32'(exp_dout));
      end
    end
  end

  task automatic send_bit(input logic b, input bit gap);
    @(posedge clk);
    bus_if.sin = b;
    bus_if.en  = 1'b1;
    if (gap) begin
      @(posedge clk);
      bus_if.en  = 1'b0;
      bus_if.sin = 1'($urandom);
    end
  endtask

  // gap_mode: 0 none, 1 en low after every bit, 2 random gaps
  task automatic send_frame(input logic [W-1:0] word, input logic stop_bit,
                            input logic par_bit, input int gap_mode);
    exp_t e;
    bit   g;
    e.good = stop_bit;
    e.data = word;
    e.perr = stop_bit && PAR_EN && ((^word) != par_bit);
    sb.push_back(e);
    g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
    send_bit(1'b0, g);
    @(negedge clk); #1;
    chk("busy_after_start", 32'(bus_if.busy), 32'd1);
    for (int i = 0; i < int'(W); i++) begin
      g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
      send_bit(word[i], g);
    end
    if (PAR_EN) begin
      g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
      send_bit(par_bit, g);
    end
    g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
    send_bit(stop_bit, g);
    if (!g) begin
      @(negedge clk); #1;
      chk("pulse_on_stop_edge", 32'(bus_if.valid | bus_if.frame_err), 32'd1);
      chk("busy_after_stop", 32'(bus_if.busy), 32'd0);
    end
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      bus_if.sin = 1'b1;
      bus_if.en  = 1'($urandom);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    checks     = 0;
    errors     = 0;
    exp_dout   = '0;
    clr_n      = 1'b1;
    bus_if.sin = 1'b1;
    bus_if.en  = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    chk("reset_data_out",  32'(bus_if.data_out),  32'd0);
    chk("reset_valid",     32'(bus_if.valid),     32'd0);
    chk("reset_frame_err", 32'(bus_if.frame_err), 32'd0);
    chk("reset_busy",      32'(bus_if.busy),      32'd0);
    @(posedge clk);
    clr_n     = 1'b1;
    bus_if.en = 1'b1;
    idle_bits(2);

    send_frame(8'hA5, 1'b1, ^8'hA5, 0);
    send_frame(8'h0F, 1'b0, 1'b0, 0);
    idle_bits(2);
    chk("bad_stop_keeps_data", 32'(bus_if.data_out), 32'hA5);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1);
    idle_bits(2);
    chk("gapped_word", 32'(bus_if.data_out), 32'h3C);

    // Abort a frame after four data bits with an asynchronous reset.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("midreset_busy",     32'(bus_if.busy),     32'd0);
    chk("midreset_data_out", 32'(bus_if.data_out), 32'd0);
    exp_dout = '0;
    #1 clr_n = 1'b1;
    bus_if.sin = 1'b1;
    idle_bits(1);
    send_frame(8'hFF, 1'b1, ^8'hFF, 0);
    idle_bits(1);
    chk("after_reset_word", 32'(bus_if.data_out), 32'hFF);

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b1, 0);
      send_frame(8'h07, 1'b1, 1'b0, 0);
    end

    // Randomized traffic, including back-to-back frames and gaps.
    for (int n = 0; n < 40; n++) begin
      w = W'($urandom);
      send_frame(w, ($urandom_range(0, 9) != 0), 1'($urandom),
                 int'($urandom_range(0, 2)));
      idle_bits(int'($urandom_range(0, 2)));
    end

    idle_bits(4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("final_data_out", 32'(bus_if.data_out), 32'(exp_dout));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
